microwave_timer: RTL and testbench
==================================

Name: microwave_timer

Overview:
Cook-time entry and countdown block that sits on the plant side of the microwave controller. It accepts BCD keypad digits and counts the time down at a 1 s tick while the controller drives heat. It produces the level finish signal that the controller consumes. finish stays high until the door opens, so the controller's bell state always has a defined exit.

Parameters:
TICK_DIV, 50_000_000, clk cycles per countdown tick (1 s); minimum 2
CW, $clog2(TICK_DIV), prescaler width (derived, not overridden)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  BCD digit 0-9; values 10-15 ignored
clear  in  1  one-cycle strobe, zero the time
heat  in  1  from controller; high = cooking, count down
door  in  1  door open (same signal the controller sees)
finish  out  1  level; cook time expired
time_bcd  out  16  {m10,m1,s10,s1} BCD, current remaining time
running  out  1  high in RUN state

Behaviour:
- Reset is clk and nrst, asynchronous active-low. State IDLE, time_bcd=16'h0000, prescaler=0, finish=0, running=0.
- States: IDLE (time zero), ARMED (time nonzero, heat low), RUN (heat high, counting), DONE (finish=1). finish is 1 iff state==DONE. running is 1 iff state==RUN. Both are registered.
- Key entry is accepted in IDLE/ARMED only.
  - A valid digit shifts left into s1: {m10,m1,s10,s1} <= {m1,s10,s1,d}; the old m10 is discarded.
  - After the shift: nonzero time -> ARMED, zero -> IDLE.
  - key_valid in RUN/DONE is ignored. key_digit >9 is ignored in all states.
- clear in IDLE/ARMED/RUN sets time=0, prescaler=0, state=IDLE. clear is ignored in DONE.
- clear and key_valid in the same cycle: clear wins.
- ARMED & heat -> RUN on the next edge. IDLE & heat (zero time) -> DONE on the next edge, so the controller is never left cooking without an end.
- RUN:
  - Prescaler increments each cycle while heat=1.
  - When prescaler==TICK_DIV-1: prescaler<=0 and time decrements.
  - If the time before the decrement is 16'h0001 / any value decrementing to 0000, state<=DONE on the same edge.
- heat low in RUN -> ARMED. The prescaler value is held, not cleared, so resume is exact.
- Decrement rule, BCD with minute:second borrow:
  - s1>0: s1-1.
  - else s1=9, and s10>0: s10-1.
  - else s10=5, and m1>0: m1-1.
  - else m1=9, m10-1.
- Entered values with s10>5 (e.g. 0090) are legal. They count down through 0089 … 0000 without normalisation.
- Latency: from the first edge with heat=1 in ARMED, one edge to reach RUN. Then N·TICK_DIV edges to finish=1 for an entered time of N seconds.
- DONE: finish held until door=1. door=1 -> IDLE, finish=0, time=0000, prescaler=0 on the next edge. heat is ignored in DONE.
- Reset mid-operation returns immediately to the reset values, asynchronously.

Decomposition:
- microwave_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} mwt_state_t
  - typedef logic [3:0] bcd_t
  - localparam bcd_t BCD_MAX_SEC_TENS = 4'd5
- Sub-module mw_bcd_countdown is purely combinational: 16-bit BCD time in, decremented time out, plus is_zero and is_one flags. It is reused by the display path.
- The prescaler and FSM stay in microwave_timer.

Test Plan:
All scenarios use TICK_DIV=4.
1. Keys 1,2; heat=1 held -> running=1 after 1 edge; time 0011 after 4 more edges; finish=1 exactly 48 edges after RUN entry; time_bcd=0000.
2. Keys 1,0,0 (0100); heat=1 for 1+4 edges -> time_bcd=16'h0059; heat dropped -> state ARMED, time frozen at 0059.
3. Keys 3; heat=1 for 1+2 edges; heat=0 for 10 edges; heat=1 -> the next decrement occurs 1+2 edges after heat returns, confirming the prescaler was retained.
4. No keys (0000); heat=1 -> finish=1 on the next edge. Keys pressed in DONE -> time_bcd stays 0000. door=1 -> finish=0, state IDLE next edge.
5. Keys 5,5,5,5,7 -> time_bcd=16'h5557. key_digit=12 strobe -> unchanged. clear+key_valid same cycle -> 0000. Key during RUN -> ignored.
6. Running with time 0010; assert nrst=0 between edges -> finish, running, time_bcd at 0 immediately. Release -> IDLE, accepts keys normally.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types for the microwave cook timer: FSM states and BCD digit type.
package microwave_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} mwt_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/mw_bcd_countdown.sv
// Combinational one-second decrement of an {m10,m1,s10,s1} BCD time with
// minute:second borrow; also flags zero and one-second values.
module mw_bcd_countdown
    import microwave_pkg::*;
(
    input  logic [15:0] time_in,
    output logic [15:0] time_out,
    output logic        is_zero,
    output logic        is_one
);

    bcd_t m10, m1, s10, s1;

    assign m10 = time_in[15:12];
    assign m1  = time_in[11:8];
    assign s10 = time_in[7:4];
    assign s1  = time_in[3:0];

    assign is_zero = (time_in == 16'h0000);
    assign is_one  = (time_in == 16'h0001);

    // Borrow ripples s1 -> s10 -> m1 -> m10; tens of seconds refill to 5,
    // so entered values like 0090 simply count down without normalisation.
    always_comb begin
        time_out = time_in;
        if (s1 != 4'd0) begin
            time_out[3:0] = s1 - 4'd1;
        end else begin
            time_out[3:0] = 4'd9;
            if (s10 != 4'd0) begin
                time_out[7:4] = s10 - 4'd1;
            end else begin
                time_out[7:4] = BCD_MAX_SEC_TENS;
                if (m1 != 4'd0) begin
                    time_out[11:8] = m1 - 4'd1;
                end else begin
                    time_out[11:8]  = 4'd9;
                    time_out[15:12] = m10 - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time entry and countdown: BCD keypad entry, 1 s countdown while heat
// is high, and a level finish that holds until the door opens.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter  int TICK_DIV = 50_000_000,
    localparam int CW       = $clog2(TICK_DIV)
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        clear,
    input  logic        heat,
    input  logic        door,
    output logic        finish,
    output logic [15:0] time_bcd,
    output logic        running
);

    localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

    mwt_state_t    state;
    logic [CW-1:0] presc;
    logic [15:0]   dec_time;
    logic [15:0]   key_time;
    logic          is_zero;
    logic          is_one;
    logic          key_ok;

    mw_bcd_countdown u_countdown (
        .time_in  (time_bcd),
        .time_out (dec_time),
        .is_zero  (is_zero),
        .is_one   (is_one)
    );

    // key_valid and clear are single-cycle strobes sampled on every edge with
    // no backpressure: a strobe outside IDLE/ARMED (clear: outside DONE) is lost.
    assign key_ok   = key_valid && (key_digit <= 4'd9);
    assign key_time = {time_bcd[11:0], key_digit};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            time_bcd <= 16'h0000;
            presc    <= '0;
            finish   <= 1'b0;
            running  <= 1'b0;
        end else begin
            case (state)
                IDLE, ARMED: begin
                    if (clear) begin
                        time_bcd <= 16'h0000;
                        presc    <= '0;
                        state    <= IDLE;
                    end else if (key_ok) begin
                        time_bcd <= key_time;
                        state    <= (key_time != 16'h0000) ? ARMED : IDLE;
                    end else if (heat) begin
                        // Heat with nothing to count ends at once so the
                        // controller always sees a finish.
                        if (is_zero) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (clear) begin
                        time_bcd <= 16'h0000;
                        presc    <= '0;
                        state    <= IDLE;
                        running  <= 1'b0;
                    end else if (!heat) begin
                        // Prescaler is held so a resumed cook loses no time.
                        state   <= ARMED;
                        running <= 1'b0;
                    end else if (presc == PRESC_MAX) begin
                        presc    <= '0;
                        time_bcd <= dec_time;
                        if (is_one) begin
                            state   <= DONE;
                            finish  <= 1'b1;
                            running <= 1'b0;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                DONE: begin
                    if (door) begin
                        time_bcd <= 16'h0000;
                        presc    <= '0;
                        state    <= IDLE;
                        finish   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Scoreboard bench for microwave_timer: directed scenarios then random
// stimulus, checked against a seconds/minutes arithmetic reference model.
module tb_microwave_timer;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        clear;
    logic        heat;
    logic        door;
    logic        finish;
    logic [15:0] time_bcd;
    logic        running;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    // Reference model: 0 idle, 1 armed, 2 run, 3 done; time kept as minutes
    // and seconds, with a cycle count toward the next one-second tick.
    int m_state;
    int m_min;
    int m_sec;
    int m_cnt;

    microwave_timer #(.TICK_DIV(TICK)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .clear     (clear),
        .heat      (heat),
        .door      (door),
        .finish    (finish),
        .time_bcd  (time_bcd),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got {finish,running,time}=%h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int mi, input int se);
        return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
    endfunction

    function automatic logic [17:0] model_out();
        return {m_state == 3, m_state == 2, to_bcd(m_min, m_sec)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_min   = 0;
        m_sec   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kd, input logic c,
                              input logic h, input logic d);
        int d3, d2, d1;
        case (m_state)
            0, 1: begin
                if (c) begin
                    model_reset();
                end else if (kv && kd <= 4'd9) begin
                    d3 = m_min % 10;
                    d2 = m_sec / 10;
                    d1 = m_sec % 10;
                    m_min = d3 * 10 + d2;
                    m_sec = d1 * 10 + int'(kd);
                    m_state = (m_min != 0 || m_sec != 0) ? 1 : 0;
                end else if (h) begin
                    m_state = (m_state == 1) ? 2 : 3;
                end
            end
            2: begin
                if (c) begin
                    model_reset();
                end else if (!h) begin
                    m_state = 1;
                end else if (m_cnt == TICK - 1) begin
                    m_cnt = 0;
                    if (m_sec > 0) begin
                        m_sec = m_sec - 1;
                    end else begin
                        m_sec = 59;
                        m_min = m_min - 1;
                    end
                    if (m_min == 0 && m_sec == 0) m_state = 3;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            default: begin
                if (d) model_reset();
            end
        endcase
    endtask

    // Called at a falling edge: drive, let one rising edge pass, record the
    // model's prediction, and return at the next falling edge.
    task automatic cycle(input logic kv, input logic [3:0] kd, input logic c,
                         input logic h, input logic d);
        key_valid = kv;
        key_digit = kd;
        clear     = c;
        heat      = h;
        door      = d;
        @(posedge clk);
        model_step(kv, kd, c, h, d);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] kd);
        cycle(1'b1, kd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hold(input logic h, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, h, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [17:0] exp;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("cycle", {finish, running, time_bcd}, exp);
        end
    end

    initial begin
        logic h_rand;
        nrst = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        clear = 1'b0;
        heat = 1'b0;
        door = 1'b0;
        model_reset();
        #12;
        check("reset", {finish, running, time_bcd}, 18'h0);
        @(negedge clk);
        nrst = 1'b1;

        // 12 s cook to finish, then door
        key(4'd1); key(4'd2);
        hold(1'b1, 52);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 0100 -> 0059 minute borrow, then pause
        key(4'd1); key(4'd0); key(4'd0);
        hold(1'b1, 5);
        hold(1'b0, 3);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // pause/resume keeps prescaler phase
        key(4'd3);
        hold(1'b1, 3);
        hold(1'b0, 10);
        hold(1'b1, 5);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // heat with zero time, keys in DONE, door exit
        hold(1'b1, 1);
        key(4'd5);
        hold(1'b1, 3);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 1);

        // entry overflow, bad digit, clear beats key, key during RUN
        key(4'd5); key(4'd5); key(4'd5); key(4'd5); key(4'd7);
        key(4'd12);
        cycle(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        key(4'd9); key(4'd0);
        hold(1'b1, 2);
        cycle(1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 6);
        cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        hold(1'b0, 1);

        // asynchronous reset while running
        key(4'd1); key(4'd0);
        hold(1'b1, 3);
        #2;
        nrst = 1'b0;
        heat = 1'b0;
        #1;
        check("async_reset", {finish, running, time_bcd}, 18'h0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        key(4'd4);
        hold(1'b1, 6);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // random traffic with slowly changing heat
        h_rand = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) h_rand = ~h_rand;
            cycle(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) == 0), h_rand,
                  ($urandom_range(0, 29) == 0));
        end

        @(negedge clk);
        check("queue_drained", 18'(exp_q.size()), 18'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
